// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with a registered, time-multiplexed digit scanner.
// Define BCD_SCAN_BLANK_EN to blank leading-zero digits above index 0.
module bcd_scan_counter #(
  parameter int PRESCALE = 4,
  parameter int SCAN_DIV = 2,
  parameter int DP_POS   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        up_dn,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        dp,
  output logic [3:0]  digit_sel,
  output logic        wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic [SW-1:0] sdiv_q, sdiv_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    code_q, code_d;
  logic [3:0]    sel_q, sel_d;
  logic          dp_q, dp_d;
  logic          tick;
  logic [3:0]    zhi;

  function automatic logic [15:0] sat_load(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple carry/borrow through the four decades.
  function automatic logic [15:0] bcd_step(
    input logic [15:0] v,
    input logic        up
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (up) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign tick = en && (presc_q == P_LAST);

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (clear) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (load) begin
      presc_d = '0;
      cnt_d   = sat_load(load_val);
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = bcd_step(cnt_q, up_dn);
      wrap_d  = up_dn ? (cnt_q == 16'h9999)
                      : (cnt_q == 16'h0000);
    end else if (en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_comb begin
    sdiv_d = sdiv_q + 1'b1;
    idx_d  = idx_q;
    if (sdiv_q == S_LAST) begin
      sdiv_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // zhi[i]: digit i and every digit above it are zero.
  always_comb begin
    zhi[3] = (cnt_q[15:12] == 4'd0);
    zhi[2] = zhi[3] && (cnt_q[11:8] == 4'd0);
    zhi[1] = zhi[2] && (cnt_q[7:4] == 4'd0);
    zhi[0] = 1'b0;
  end

  // Display registers describe the upcoming slot using the pre-edge count.
  always_comb begin
    code_d = cnt_q[{idx_d, 2'b00} +: 4];
    sel_d  = 4'b0001 << idx_d;
    dp_d   = (int'(idx_d) == DP_POS);
`ifdef BCD_SCAN_BLANK_EN
    if (zhi[idx_d]) begin
      code_d = 4'd0;
      sel_d  = 4'b0000;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      sdiv_q  <= '0;
      idx_q   <= 2'd0;
      code_q  <= 4'd0;
      sel_q   <= 4'b0001;
      dp_q    <= (DP_POS == 0);
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      sdiv_q  <= sdiv_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      sel_q   <= sel_d;
      dp_q    <= dp_d;
    end
  end

`ifndef BCD_SCAN_BLANK_EN
  logic unused_zhi;
  assign unused_zhi = ^zhi;
`endif

  assign {w, x, y, z} = code_q;
  assign dp           = dp_q;
  assign digit_sel    = sel_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomized self-checking bench for bcd_scan_counter against a decimal model.
// Honours BCD_SCAN_BLANK_EN in its reference model.
module tb_bcd_scan_counter;

  localparam int PRE = 4;
  localparam int SD  = 2;
  localparam int DP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        w, x, y, z, dp, wrap;
  logic [3:0]  digit_sel;

  int checks = 0;
  int errors = 0;

  int m_cnt, m_prev, m_presc, m_cyc;
  bit m_wrap;

  bcd_scan_counter #(
    .PRESCALE(PRE),
    .SCAN_DIV(SD),
    .DP_POS(DP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .up_dn(up_dn),
    .clear(clear),
    .load(load),
    .load_val(load_val),
    .w(w),
    .x(x),
    .y(y),
    .z(z),
    .dp(dp),
    .digit_sel(digit_sel),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int i);
    int r;
    r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  function automatic int sat_val(input logic [15:0] lv);
    int r;
    int n;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      n = int'((lv >> (4 * i)) & 16'hF);
      if (n > 9) n = 9;
      r = r + n * pow10(i);
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_cnt = 0;
    m_prev = 0;
    m_presc = 0;
    m_cyc = 0;
    m_wrap = 0;
  endfunction

  // {code[3:0], dp, digit_sel[3:0], wrap}
  function automatic logic [9:0] exp_out();
    int idx;
    int d;
    logic [3:0] sel;
    idx = (m_cyc / SD) % 4;
    d = (m_prev / pow10(idx)) % 10;
    sel = 4'b0001 << idx;
`ifdef BCD_SCAN_BLANK_EN
    if (idx > 0 && m_prev < pow10(idx)) begin
      sel = 4'b0000;
      d = 0;
    end
`endif
    return {4'(d), (idx == DP), sel, m_wrap};
  endfunction

  function automatic logic [9:0] obs();
    return {w, x, y, z, dp, digit_sel, wrap};
  endfunction

  task automatic step(input bit c_clr, input bit c_ld, input bit c_en,
                      input bit c_up, input logic [15:0] lv);
    clear = c_clr;
    load = c_ld;
    en = c_en;
    up_dn = c_up;
    load_val = lv;
    @(posedge clk);
    m_prev = m_cnt;
    m_wrap = 0;
    if (c_clr) begin
      m_cnt = 0;
      m_presc = 0;
    end else if (c_ld) begin
      m_cnt = sat_val(lv);
      m_presc = 0;
    end else if (c_en) begin
      if (m_presc == PRE - 1) begin
        m_presc = 0;
        if (c_up) begin
          if (m_cnt == 9999) begin m_cnt = 0; m_wrap = 1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = 9999; m_wrap = 1; end
          else m_cnt = m_cnt - 1;
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end
    m_cyc = m_cyc + 1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (obs() !== 10'b0000_0_0001_0) begin
      errors++;
      $display("FAIL reset_const: got %b exp %b", obs(), 10'b0000_0_0001_0);
    end
    checks++;
    if (obs() !== exp_out()) begin
      errors++;
      $display("FAIL reset_model: got %b exp %b", obs(), exp_out());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan_idle();
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, 16'h0);
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL scan_idle[%0d]: got %b exp %b", i, obs(), exp_out());
      end
      checks++;
      if (dp !== (digit_sel == 4'b0100)) begin
        errors++;
        $display("FAIL scan_dp[%0d]: dp %b sel %b", i, dp, digit_sel);
      end
    end
  endtask

  task automatic test_load_count();
    bit found;
    step(0, 1, 0, 1, 16'h0998);
    checks++;
    if (obs() !== exp_out()) begin
      errors++;
      $display("FAIL load_998: got %b exp %b", obs(), exp_out());
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 1, 16'h0);
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL count_up[%0d]: got %b exp %b", i, obs(), exp_out());
      end
    end
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(0, 0, 0, 1, 16'h0);
      if (digit_sel == 4'b1000) begin
        found = 1;
        checks++;
        if ({w, x, y, z} !== 4'b0001) begin
          errors++;
          $display("FAIL digit3_1000: got %b exp 0001", {w, x, y, z});
        end
      end
    end
    if (!found) begin
      errors++;
      $display("FAIL digit3_slot: slot 3 never seen, got none exp 1000");
    end
  endtask

  task automatic test_wrap();
    int pulses;
    step(0, 1, 0, 1, 16'h9999);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, i < 4, 1, 16'h0);
      if (wrap === 1'b1) pulses++;
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL wrap_up[%0d]: got %b exp %b", i, obs(), exp_out());
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL wrap_up_pulses: got %0d exp 1", pulses);
    end
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, i < 4, 0, 16'h0);
      if (wrap === 1'b1) pulses++;
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL wrap_dn[%0d]: got %b exp %b", i, obs(), exp_out());
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL wrap_dn_pulses: got %0d exp 1", pulses);
    end
  endtask

  task automatic test_sat_clear();
    step(0, 1, 0, 1, 16'h3AF5);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 16'h0);
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL sat[%0d]: got %b exp %b", i, obs(), exp_out());
      end
      if (digit_sel == 4'b0100) begin
        checks++;
        if ({w, x, y, z} !== 4'd9) begin
          errors++;
          $display("FAIL sat_digit2: got %b exp 1001", {w, x, y, z});
        end
      end
    end
    step(1, 1, 1, 1, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 16'h0);
      checks++;
      if ({w, x, y, z} !== 4'd0 || obs() !== exp_out()) begin
        errors++;
        $display("FAIL clear_load[%0d]: got %b exp %b", i, obs(), exp_out());
      end
    end
  endtask

  task automatic test_blank_0042();
    step(0, 1, 0, 1, 16'h0042);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 16'h0);
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL show_0042[%0d]: got %b exp %b", i, obs(), exp_out());
      end
    end
  endtask

  task automatic test_random();
    bit c, l, e, u;
    logic [15:0] lv;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(31) == 0);
      l = ($urandom_range(15) == 0);
      e = ($urandom_range(3) != 0);
      u = 1'($urandom_range(1));
      lv = 16'($urandom);
      step(c, l, e, u, lv);
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL random[%0d]: got %b exp %b", i, obs(), exp_out());
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 1, 1, 1, 16'h5678);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 10'b0000_0_0001_0) begin
      errors++;
      $display("FAIL async_reset: got %b exp %b", obs(), 10'b0000_0_0001_0);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 1, 16'h0);
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %b exp %b", i, obs(), exp_out());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan_idle();
    test_load_count();
    test_wrap();
    test_sat_clear();
    test_blank_0042();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
